// File: rtl/max_ccx_endpoint_pkg.sv
// -----------------------------------------------------------------------------
// max_ccx_endpoint_pkg
// Shared widths, frame field offsets, control-word bit positions and small
// helpers for the Maxeler-side CCX endpoint (PCX assembler / CPX serializer).
// No ports: imported by the interface, the packet FIFO and the endpoint top.
// -----------------------------------------------------------------------------
package max_ccx_endpoint_pkg;

  // Stream and payload widths
  localparam int MAX_D_WIDTH   = 32;
  localparam int PCX_WIDTH     = 124;
  localparam int CPX_WIDTH     = 145;
  localparam int WORDS_PER_PKT = 5;
  localparam int FRAME_WIDTH   = MAX_D_WIDTH * WORDS_PER_PKT;   // 160

  // PCX request packet: {req[4:0], atom, payload[123:0]} in frame[129:0]
  localparam int PCX_REQ_WIDTH = 5;
  localparam int PCX_ATOM_BIT  = PCX_WIDTH;                     // 124
  localparam int PCX_REQ_LSB   = PCX_WIDTH + 1;                 // 125
  localparam int PCX_PKT_WIDTH = PCX_WIDTH + 1 + PCX_REQ_WIDTH; // 130

  // Bits of the assembly register that hold words 0..3 of a frame
  localparam int PCX_ASM_WIDTH = FRAME_WIDTH - MAX_D_WIDTH;     // 128
  // Bits of word0 that carry packet content; the rest must be zero pad
  localparam int PCX_HDR_USED  = PCX_PKT_WIDTH - PCX_ASM_WIDTH; // 2

  // CPX frame: payload in frame[144:0], zero pad above
  localparam int CPX_PAD_WIDTH = FRAME_WIDTH - CPX_WIDTH;       // 15

  // CPX packet FIFO sizing and low-water mark
  localparam int CPX_PKT_DEPTH = 2;
  localparam int CPX_CNT_WIDTH = $clog2(CPX_PKT_DEPTH) + 1;
  localparam int AE_WORDS      = 1;
  localparam int AVAIL_WIDTH   = 4;                             // up to 10 words

  // Control word bit positions
  localparam int CTL_VALID = 4;
  localparam int CTL_FIRST = 3;

  // Word index within a frame
  localparam int WIDX_WIDTH = 3;

  typedef logic [MAX_D_WIDTH-1:0] word_t;
  typedef logic [FRAME_WIDTH-1:0] frame_t;
  typedef logic [WIDX_WIDTH-1:0]  widx_t;

  localparam widx_t FIRST_WORD = 3'd0;
  localparam widx_t LAST_WORD  = 3'd4;

  typedef struct packed {
    logic [PCX_REQ_WIDTH-1:0] req;
    logic                     atom;
    logic [PCX_WIDTH-1:0]     payload;
  } pcx_pkt_t;

  // Word idx of a frame, MS word first; out-of-range index yields zero
  function automatic word_t frame_word(input frame_t f, input widx_t idx);
    word_t w;
    w = 32'h0000_0000;
    case (idx)
      3'd0:    w = f[159:128];
      3'd1:    w = f[127:96];
      3'd2:    w = f[95:64];
      3'd3:    w = f[63:32];
      3'd4:    w = f[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Nonzero pad above the req bits of a PCX header word
  function automatic logic pcx_hdr_bad(input word_t w);
    return |w[MAX_D_WIDTH-1:PCX_HDR_USED];
  endfunction

endpackage

// File: rtl/max_ccx_endpoint_if.sv
// -----------------------------------------------------------------------------
// max_ccx_endpoint_if
// Bundles the bridge-side word streams and the packet-side handshakes of the
// CCX endpoint.
//   master : environment side (bridge writer/reader, L2 model, responder)
//   slave  : the endpoint itself
// Signals: PCX word stream in (valid/data/stall), PCX request packet out
// (valid/data/ready), CPX response packet in (valid/data/ready), CPX word
// stream out (read/data/ctl/empty/almost_empty), sticky error flags.
// -----------------------------------------------------------------------------
interface max_ccx_endpoint_if;
  import max_ccx_endpoint_pkg::*;

  logic                     max_pcx_valid;
  word_t                    max_pcx_data;
  logic                     max_pcx_stall;
  logic                     pcx_pkt_valid;
  logic [PCX_PKT_WIDTH-1:0] pcx_pkt_data;
  logic                     pcx_pkt_ready;
  logic                     cpx_pkt_valid;
  logic [CPX_WIDTH-1:0]     cpx_pkt_data;
  logic                     cpx_pkt_ready;
  logic                     max_cpx_read;
  word_t                    max_cpx_data;
  word_t                    max_cpx_ctl_data;
  logic                     max_cpx_empty;
  logic                     max_cpx_almost_empty;
  logic                     frame_err;
  logic                     cpx_underrun;

  modport master (
    output max_pcx_valid, max_pcx_data, pcx_pkt_ready,
           cpx_pkt_valid, cpx_pkt_data, max_cpx_read,
    input  max_pcx_stall, pcx_pkt_valid, pcx_pkt_data, cpx_pkt_ready,
           max_cpx_data, max_cpx_ctl_data, max_cpx_empty,
           max_cpx_almost_empty, frame_err, cpx_underrun
  );

  modport slave (
    input  max_pcx_valid, max_pcx_data, pcx_pkt_ready,
           cpx_pkt_valid, cpx_pkt_data, max_cpx_read,
    output max_pcx_stall, pcx_pkt_valid, pcx_pkt_data, cpx_pkt_ready,
           max_cpx_data, max_cpx_ctl_data, max_cpx_empty,
           max_cpx_almost_empty, frame_err, cpx_underrun
  );

endinterface

// File: rtl/max_ccx_endpoint_fifo.sv
// -----------------------------------------------------------------------------
// ccx_pkt_fifo
// Synchronous packet FIFO, first-word-fall-through head. DEPTH must be a
// power of two >= 2. A push is taken when not full, or when full together
// with a pop in the same cycle (occupancy then stays unchanged).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write strobe and packet
//   pop               remove head packet (ignored when empty)
//   head_data         current head packet
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module ccx_pkt_fifo #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags and qualified push/pop
  always_comb begin
    empty     = (count_r == CW'(0));
    full      = (count_r == CW'(DEPTH));
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Packet storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/max_ccx_endpoint.sv
// -----------------------------------------------------------------------------
// max_ccx_endpoint
// Maxeler-side peer of the SPARC CCX word bridge.
//   PCX: gathers five 32-bit words (MS word first) into a 130-bit request
//        {req, atom, payload}, held in an output register until accepted.
//   CPX: buffers 145-bit responses in a packet FIFO and presents them as a
//        first-word-fall-through stream of five 32-bit words each.
// Ports:
//   gclk, reset  clock, synchronous active-high reset
//   bus          max_ccx_endpoint_if.slave (all stream/packet signals and
//                the sticky frame_err / cpx_underrun flags)
// -----------------------------------------------------------------------------
module max_ccx_endpoint
  import max_ccx_endpoint_pkg::*;
(
  input  logic              gclk,
  input  logic              reset,
  max_ccx_endpoint_if.slave bus
);

  // ---------------------------------------------------------------- PCX side
  widx_t                    wi_r;
  logic [PCX_ASM_WIDTH-1:0] asm_r;
  pcx_pkt_t                 pcx_out_r;
  logic                     pcx_valid_r;
  logic                     frame_err_r;

  logic   stall_s;
  logic   wr_acc_s;
  logic   pcx_load_s;
  logic   hdr_bad_s;
  frame_t pcx_frame_s;

  // Stall only while a packet is held and the next one is one word from done;
  // assembly of the following packet keeps going underneath a held output.
  always_comb begin
    stall_s     = pcx_valid_r & (wi_r == LAST_WORD) & ~bus.pcx_pkt_ready;
    wr_acc_s    = bus.max_pcx_valid & ~stall_s;
    pcx_load_s  = wr_acc_s & (wi_r == LAST_WORD);
    hdr_bad_s   = wr_acc_s & (wi_r == FIRST_WORD) & pcx_hdr_bad(bus.max_pcx_data);
    pcx_frame_s = {asm_r, bus.max_pcx_data};
  end

  // Word index and shift-in assembly register
  always_ff @(posedge gclk) begin
    if (reset) begin
      wi_r  <= FIRST_WORD;
      asm_r <= {PCX_ASM_WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      asm_r <= {asm_r[PCX_ASM_WIDTH-MAX_D_WIDTH-1:0], bus.max_pcx_data};
      wi_r  <= pcx_load_s ? FIRST_WORD : wi_r + 3'd1;
    end
  end

  // Request output register; a load in the accept cycle keeps valid high
  always_ff @(posedge gclk) begin
    if (reset) begin
      pcx_valid_r <= 1'b0;
      pcx_out_r   <= pcx_pkt_t'({PCX_PKT_WIDTH{1'b0}});
    end else if (pcx_load_s) begin
      pcx_valid_r <= 1'b1;
      pcx_out_r   <= pcx_pkt_t'(pcx_frame_s[PCX_PKT_WIDTH-1:0]);
    end else if (pcx_valid_r & bus.pcx_pkt_ready) begin
      pcx_valid_r <= 1'b0;
    end
  end

  // Sticky framing error: bad header pad, or a write that arrives during stall
  always_ff @(posedge gclk) begin
    if (reset) begin
      frame_err_r <= 1'b0;
    end else if ((bus.max_pcx_valid & stall_s) | hdr_bad_s) begin
      frame_err_r <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- CPX side
  logic [CPX_WIDTH-1:0]     head_s;
  logic [CPX_CNT_WIDTH-1:0] cnt_s;
  logic                     full_s;
  logic                     fifo_empty_s;
  widx_t                    ri_r;
  logic                     underrun_r;

  logic [AVAIL_WIDTH-1:0] avail_s;
  logic                   empty_s;
  logic                   ae_s;
  logic                   word_pop_s;
  logic                   last_pop_s;
  logic                   cpx_ready_s;
  logic                   cpx_push_s;
  word_t                  cpx_word_s;
  word_t                  cpx_ctl_s;

  // Word availability and read/push qualification. Ready also opens on the
  // cycle the last word of the head leaves, so a full FIFO can swap a packet.
  always_comb begin
    avail_s     = AVAIL_WIDTH'(cnt_s) * AVAIL_WIDTH'(WORDS_PER_PKT) - AVAIL_WIDTH'(ri_r);
    empty_s     = (avail_s == {AVAIL_WIDTH{1'b0}});
    ae_s        = (avail_s <= AVAIL_WIDTH'(AE_WORDS));
    word_pop_s  = bus.max_cpx_read & ~empty_s;
    last_pop_s  = word_pop_s & (ri_r == LAST_WORD);
    cpx_ready_s = ~reset & (~full_s | last_pop_s);
    cpx_push_s  = bus.cpx_pkt_valid & cpx_ready_s;
  end

  // Current stream word and control flags, forced to zero with no packet
  always_comb begin
    cpx_word_s = 32'h0000_0000;
    cpx_ctl_s  = 32'h0000_0000;
    if (~fifo_empty_s) begin
      cpx_word_s            = frame_word({{CPX_PAD_WIDTH{1'b0}}, head_s}, ri_r);
      cpx_ctl_s[CTL_VALID]  = 1'b1;
      cpx_ctl_s[CTL_FIRST]  = (ri_r == FIRST_WORD);
    end else begin
      cpx_word_s = 32'h0000_0000;
      cpx_ctl_s  = 32'h0000_0000;
    end
  end

  // Read index over the head packet
  always_ff @(posedge gclk) begin
    if (reset) begin
      ri_r <= FIRST_WORD;
    end else if (word_pop_s) begin
      ri_r <= (ri_r == LAST_WORD) ? FIRST_WORD : ri_r + 3'd1;
    end
  end

  // Sticky underrun on a read with nothing available
  always_ff @(posedge gclk) begin
    if (reset) begin
      underrun_r <= 1'b0;
    end else if (bus.max_cpx_read & empty_s) begin
      underrun_r <= 1'b1;
    end
  end

  ccx_pkt_fifo #(
    .WIDTH (CPX_WIDTH),
    .DEPTH (CPX_PKT_DEPTH)
  ) u_cpx_fifo (
    .clk       (gclk),
    .reset     (reset),
    .push      (cpx_push_s),
    .push_data (bus.cpx_pkt_data),
    .pop       (last_pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (fifo_empty_s),
    .count     (cnt_s)
  );

  // ---------------------------------------------------------------- outputs
  assign bus.max_pcx_stall        = stall_s;
  assign bus.pcx_pkt_valid        = pcx_valid_r;
  assign bus.pcx_pkt_data         = pcx_out_r;
  assign bus.cpx_pkt_ready        = cpx_ready_s;
  assign bus.max_cpx_data         = cpx_word_s;
  assign bus.max_cpx_ctl_data     = cpx_ctl_s;
  assign bus.max_cpx_empty        = empty_s;
  assign bus.max_cpx_almost_empty = ae_s;
  assign bus.frame_err            = frame_err_r;
  assign bus.cpx_underrun         = underrun_r;

endmodule

// File: tb/tb_max_ccx_endpoint.sv
// -----------------------------------------------------------------------------
// tb_max_ccx_endpoint
// Directed stimulus for max_ccx_endpoint. A queue-based model (words pending
// for the PCX packet, words remaining in the CPX stream) is stepped on every
// rising edge and compared against all outputs on every falling edge; literal
// expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_max_ccx_endpoint;
  import max_ccx_endpoint_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  max_ccx_endpoint_if bus ();

  max_ccx_endpoint dut (
    .gclk  (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // ------------------------------------------------------------ model state
  logic [31:0]  pq[$];      // PCX words gathered toward the next packet
  logic [31:0]  cq[$];      // CPX words still to be read, in order
  bit           m_pvalid;
  logic [129:0] m_pdata;
  bit           m_ferr;
  bit           m_under;

  function automatic bit m_stall();
    return m_pvalid && (pq.size() == 4) && !bus.pcx_pkt_ready;
  endfunction

  // Room for a packet: fewer than two packets held, or the last word of the
  // head packet is being read right now.
  function automatic bit m_cready();
    if (reset) return 1'b0;
    return (((cq.size() + 4) / 5) < 2) || (bus.max_cpx_read && (cq.size() % 5 == 1));
  endfunction

  task automatic model_step();
    bit st;
    bit rdy;
    logic [159:0] fr;
    if (reset) begin
      pq.delete();
      cq.delete();
      m_pvalid = 1'b0;
      m_pdata  = '0;
      m_ferr   = 1'b0;
      m_under  = 1'b0;
      return;
    end
    st  = m_stall();
    rdy = m_cready();
    if (m_pvalid && bus.pcx_pkt_ready) m_pvalid = 1'b0;
    if (bus.max_pcx_valid) begin
      if (st) begin
        m_ferr = 1'b1;
      end else begin
        if (pq.size() == 0 && bus.max_pcx_data[31:2] != 30'd0) m_ferr = 1'b1;
        pq.push_back(bus.max_pcx_data);
        if (pq.size() == 5) begin
          fr = {pq[0], pq[1], pq[2], pq[3], pq[4]};
          pq.delete();
          m_pvalid = 1'b1;
          m_pdata  = fr[129:0];
        end
      end
    end
    if (bus.max_cpx_read) begin
      if (cq.size() == 0) m_under = 1'b1;
      else void'(cq.pop_front());
    end
    if (bus.cpx_pkt_valid && rdy) begin
      fr = {15'd0, bus.cpx_pkt_data};
      for (int i = 0; i < 5; i++) cq.push_back(fr[159-32*i -: 32]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ------------------------------------------------------------ checking
  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk_bit("m_stall", bus.max_pcx_stall, m_stall());
    chk_bit("m_pcx_valid", bus.pcx_pkt_valid, m_pvalid);
    if (m_pvalid) chk_vec("m_pcx_data", 160'(bus.pcx_pkt_data), 160'(m_pdata));
    chk_bit("m_cpx_ready", bus.cpx_pkt_ready, m_cready());
    chk_bit("m_cpx_empty", bus.max_cpx_empty, cq.size() == 0);
    chk_bit("m_cpx_ae", bus.max_cpx_almost_empty, cq.size() <= AE_WORDS);
    chk_vec("m_cpx_ctl", 160'(bus.max_cpx_ctl_data),
            (cq.size() == 0) ? 160'h0 : ((cq.size() % 5 == 0) ? 160'h18 : 160'h10));
    if (cq.size() > 0) chk_vec("m_cpx_data", 160'(bus.max_cpx_data), 160'(cq[0]));
    chk_bit("m_frame_err", bus.frame_err, m_ferr);
    chk_bit("m_underrun", bus.cpx_underrun, m_under);
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) compare_all();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pcx_write(input logic [31:0] w);
    int n;
    n = 0;
    while (bus.max_pcx_stall === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL pcx_write_wait: stall still %b after %0d cycles", bus.max_pcx_stall, n);
    end
    bus.max_pcx_valid = 1'b1;
    bus.max_pcx_data  = w;
    tick();
    bus.max_pcx_valid = 1'b0;
  endtask

  task automatic pcx_frame(input logic [159:0] f);
    for (int i = 0; i < 5; i++) pcx_write(f[159-32*i -: 32]);
  endtask

  function automatic logic [159:0] pcx_fr(input logic [4:0] req, input logic atom,
                                          input logic [123:0] pl);
    return {30'd0, req, atom, pl};
  endfunction

  logic [127:0] pat;
  logic [123:0] pl_a, pl_b, pl_c, pl_d, pl_e;
  logic [159:0] f1, f2a, f2b, f3, f4, f6, fh;
  logic [144:0] cpx_a, cpx_b, cpx_c;

  initial begin
    bus.max_pcx_valid = 1'b0;
    bus.max_pcx_data  = 32'h0;
    bus.pcx_pkt_ready = 1'b0;
    bus.cpx_pkt_valid = 1'b0;
    bus.cpx_pkt_data  = '0;
    bus.max_cpx_read  = 1'b0;

    pat  = {16{8'hA5}};
    pl_a = pat[123:0];
    pat  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    pl_b = pat[123:0];
    pat  = 128'hFEDC_BA98_7654_3210_1122_3344_5566_7788;
    pl_c = pat[123:0];
    pat  = 128'h1357_9BDF_2468_ACE0_DEAD_BEEF_CAFE_F00D;
    pl_d = pat[123:0];
    pat  = 128'h0F0F_0F0F_F0F0_F0F0_3C3C_3C3C_C3C3_C3C3;
    pl_e = pat[123:0];
    f1  = pcx_fr(5'b00100, 1'b1, pl_a);
    f2a = pcx_fr(5'b01010, 1'b0, pl_b);
    f2b = pcx_fr(5'b10001, 1'b1, pl_c);
    f3  = pcx_fr(5'b00011, 1'b0, pl_d);
    f4  = pcx_fr(5'b11111, 1'b1, pl_e);
    f6  = pcx_fr(5'b00110, 1'b0, pl_c);
    fh  = {32'h0000_0004, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    cpx_a = {17'h15A5A, 128'h0123_4567_89AB_CDEF_DEAD_BEEF_0BAD_F00D};
    cpx_b = {17'h00B0B, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    cpx_c = {17'h1FFFF, 128'hCAFE_0000_CAFE_1111_CAFE_2222_CAFE_3333};

    // Reset state
    tick();
    cmp_en = 1'b1;
    tick();
    chk_bit("rst_pcx_valid", bus.pcx_pkt_valid, 1'b0);
    chk_bit("rst_stall", bus.max_pcx_stall, 1'b0);
    chk_bit("rst_cpx_ready", bus.cpx_pkt_ready, 1'b0);
    chk_bit("rst_empty", bus.max_cpx_empty, 1'b1);
    chk_bit("rst_ae", bus.max_cpx_almost_empty, 1'b1);
    chk_vec("rst_ctl", 160'(bus.max_cpx_ctl_data), 160'h0);
    chk_bit("rst_frame_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    tick();

    // 1. PCX packet, valid one cycle after the final word
    for (int i = 0; i < 4; i++) pcx_write(f1[159-32*i -: 32]);
    chk_bit("t1_valid_before_last", bus.pcx_pkt_valid, 1'b0);
    pcx_write(f1[31:0]);
    chk_bit("t1_valid_after_last", bus.pcx_pkt_valid, 1'b1);
    chk_vec("t1_pkt_data", 160'(bus.pcx_pkt_data), 160'({5'b00100, 1'b1, pl_a}));
    bus.pcx_pkt_ready = 1'b1;
    tick();
    chk_bit("t1_valid_drop", bus.pcx_pkt_valid, 1'b0);

    // 2. Back-pressure over ten words
    bus.pcx_pkt_ready = 1'b0;
    pcx_frame(f2a);
    for (int i = 0; i < 4; i++) pcx_write(f2b[159-32*i -: 32]);
    chk_bit("t2_stall", bus.max_pcx_stall, 1'b1);
    tick();
    tick();
    chk_vec("t2_first_held", 160'(bus.pcx_pkt_data), 160'({5'b01010, 1'b0, pl_b}));
    bus.pcx_pkt_ready = 1'b1;
    #1;
    chk_bit("t2_stall_release", bus.max_pcx_stall, 1'b0);
    pcx_write(f2b[31:0]);
    chk_bit("t2_second_valid", bus.pcx_pkt_valid, 1'b1);
    chk_vec("t2_second_data", 160'(bus.pcx_pkt_data), 160'({5'b10001, 1'b1, pl_c}));
    tick();

    // 3b. Write while stalled is dropped and flagged
    bus.pcx_pkt_ready = 1'b0;
    pcx_frame(f3);
    for (int i = 0; i < 4; i++) pcx_write(f4[159-32*i -: 32]);
    bus.max_pcx_valid = 1'b1;
    bus.max_pcx_data  = 32'hDEAD_BEEF;
    tick();
    bus.max_pcx_valid = 1'b0;
    chk_bit("t3_stall_write_err", bus.frame_err, 1'b1);
    chk_vec("t3_held_pkt", 160'(bus.pcx_pkt_data), 160'({5'b00011, 1'b0, pl_d}));
    bus.pcx_pkt_ready = 1'b1;
    #1;
    pcx_write(f4[31:0]);
    chk_vec("t3_next_pkt", 160'(bus.pcx_pkt_data), 160'({5'b11111, 1'b1, pl_e}));
    tick();

    // 4. CPX serialize from an idle FIFO
    bus.cpx_pkt_valid = 1'b1;
    bus.cpx_pkt_data  = cpx_a;
    tick();
    bus.cpx_pkt_valid = 1'b0;
    chk_bit("t4_not_empty", bus.max_cpx_empty, 1'b0);
    chk_vec("t4_ctl_first", 160'(bus.max_cpx_ctl_data), 160'h18);
    chk_vec("t4_word0", 160'(bus.max_cpx_data), 160'h0001_5A5A);
    chk_bit("t4_ae_low", bus.max_cpx_almost_empty, 1'b0);
    bus.max_cpx_read = 1'b1;
    tick();
    chk_vec("t4_ctl_next", 160'(bus.max_cpx_ctl_data), 160'h10);
    chk_vec("t4_word1", 160'(bus.max_cpx_data), 160'h0123_4567);
    tick();
    tick();
    tick();
    chk_bit("t4_ae_last", bus.max_cpx_almost_empty, 1'b1);
    chk_vec("t4_word4", 160'(bus.max_cpx_data), 160'h0BAD_F00D);
    tick();
    bus.max_cpx_read = 1'b0;
    chk_bit("t4_empty_end", bus.max_cpx_empty, 1'b1);

    // 5. CPX full: swap a packet in on the final-word pop
    bus.cpx_pkt_valid = 1'b1;
    bus.cpx_pkt_data  = cpx_b;
    tick();
    bus.cpx_pkt_data  = cpx_c;
    tick();
    bus.cpx_pkt_data  = cpx_a;
    chk_bit("t5_ready_full", bus.cpx_pkt_ready, 1'b0);
    tick();
    bus.max_cpx_read = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_bit("t5_ready_swap", bus.cpx_pkt_ready, 1'b1);
    tick();
    bus.max_cpx_read  = 1'b0;
    bus.cpx_pkt_valid = 1'b0;
    chk_bit("t5_still_full", bus.cpx_pkt_ready, 1'b0);
    chk_vec("t5_next_head", 160'(bus.max_cpx_data), 160'h0001_FFFF);
    bus.max_cpx_read = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.max_cpx_read = 1'b0;
    chk_bit("t5_drained", bus.max_cpx_empty, 1'b1);

    // 6. Reset mid-packet on both paths
    pcx_write(f6[159:128]);
    pcx_write(f6[127:96]);
    bus.cpx_pkt_valid = 1'b1;
    bus.cpx_pkt_data  = cpx_b;
    tick();
    bus.cpx_pkt_valid = 1'b0;
    bus.max_cpx_read  = 1'b1;
    tick();
    tick();
    tick();
    bus.max_cpx_read = 1'b0;
    reset = 1'b1;
    tick();
    chk_bit("t6_empty", bus.max_cpx_empty, 1'b1);
    chk_vec("t6_ctl", 160'(bus.max_cpx_ctl_data), 160'h0);
    chk_bit("t6_frame_err_clr", bus.frame_err, 1'b0);
    reset = 1'b0;
    bus.pcx_pkt_ready = 1'b0;
    pcx_frame(f6);
    chk_bit("t6_clean_valid", bus.pcx_pkt_valid, 1'b1);
    chk_vec("t6_clean_pkt", 160'(bus.pcx_pkt_data), 160'({5'b00110, 1'b0, pl_c}));
    bus.pcx_pkt_ready = 1'b1;
    tick();

    // 3a. Bad header pad still delivers the packet
    pcx_frame(fh);
    chk_bit("t3_hdr_err", bus.frame_err, 1'b1);
    chk_vec("t3_hdr_pkt", 160'(bus.pcx_pkt_data),
            160'({2'b00, 128'h1111_2222_3333_4444_5555_6666_7777_8888}));
    tick();

    // Read while empty
    bus.max_cpx_read = 1'b1;
    tick();
    bus.max_cpx_read = 1'b0;
    chk_bit("underrun_set", bus.cpx_underrun, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
